// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver timing defaults and state encoding.
package uart_pkg;
  localparam int BIT_TICKS_DEF  = 10415;
  localparam int HALF_TICKS_DEF = 5207;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for the serial line, resets to idle-high.
module uart_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ff <= 2'b11;
    else r_ff <= {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-bit glitch rejection, framing-error
// detection and a break state that waits for the line to return high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_TICKS  = BIT_TICKS_DEF,
  parameter int HALF_TICKS = HALF_TICKS_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_line,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam logic [15:0] BIT_END  = 16'(BIT_TICKS - 1);
  localparam logic [15:0] HALF_END = 16'(HALF_TICKS - 1);
  rx_state_e   r_state, w_state_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [2:0]  r_idx, w_idx_nx;
  logic [7:0]  r_sh, w_sh_nx;
  logic [7:0]  r_data, w_data_nx;
  logic        r_valid, w_valid_nx;
  logic        r_ferr, w_ferr_nx;
  logic        w_line;
  logic        w_bit_end;
  logic        w_half_end;
  uart_sync u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_rx_line),
    .o_q    (w_line)
  );
  assign w_bit_end  = r_cnt == BIT_END;
  assign w_half_end = r_cnt == HALF_END;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_sh    <= w_sh_nx;
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
    end
  // Every sample point resets the counter, so it never passes BIT_TICKS-1.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 16'd1;
    w_idx_nx   = r_idx;
    w_sh_nx    = r_sh;
    w_data_nx  = r_data;
    w_valid_nx = 1'b0;
    w_ferr_nx  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        if (!w_line) w_state_nx = ST_START;
      end
      ST_START:
        if (w_half_end) begin
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_state_nx = w_line ? ST_IDLE : ST_DATA;
        end
      ST_DATA:
        if (w_bit_end) begin
          w_cnt_nx        = '0;
          w_sh_nx[r_idx]  = w_line;
          w_idx_nx        = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nx = ST_STOP;
        end
      ST_STOP:
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_data_nx  = w_line ? r_sh : r_data;
          w_valid_nx = w_line;
          w_ferr_nx  = !w_line;
          w_state_nx = w_line ? ST_IDLE : ST_BREAK;
        end
      ST_BREAK: begin
        w_cnt_nx = '0;
        if (w_line) w_state_nx = ST_IDLE;
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_busy      = r_state != ST_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vectors and corner-case sequences for uart_rx,
// run with a short bit period so whole frames fit in a small cycle budget.
module tb_uart_rx;
  localparam int BT = 50;
  localparam int HT = 25;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;
  int n_tests = 0, n_fail = 0;
  int n_valid = 0, n_ferr = 0, n_busy = 0, n_both = 0;
  logic [7:0] cap[$];
  typedef struct {
    logic [7:0] data;
    int         period;
  } vec_t;
  vec_t vecs[5];
  uart_rx #(.BIT_TICKS(BT), .HALF_TICKS(HT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_line  (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (o_valid) begin
      n_valid++;
      cap.push_back(o_data);
    end
    if (o_frame_err) n_ferr++;
    if (o_busy) n_busy++;
    if (o_valid && o_frame_err) n_both++;
  end
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop, input int p);
    drive(1'b0, p);
    for (int i = 0; i < 8; i++) drive(b[i], p);
    drive(stop, p);
  endtask
  initial begin
    int v0, f0, b0, n;
    vecs[0] = '{8'hA5, BT};
    vecs[1] = '{8'h81, BT};
    vecs[2] = '{8'h3C, BT};
    vecs[3] = '{8'hC3, BT - 1};
    vecs[4] = '{8'hC3, BT + 1};
    #1;
    check("reset_data", o_data, 0);
    check("reset_valid", o_valid, 0);
    check("reset_ferr", o_frame_err, 0);
    check("reset_busy", o_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 10);
    for (int k = 0; k < 5; k++) begin
      v0 = n_valid;
      f0 = n_ferr;
      send_byte(vecs[k].data, 1'b1, vecs[k].period);
      drive(1'b1, 2 * BT);
      check($sformatf("vec%0d_valid_cnt", k), n_valid - v0, 1);
      check($sformatf("vec%0d_ferr_cnt", k), n_ferr - f0, 0);
      check($sformatf("vec%0d_data", k), o_data, vecs[k].data);
      check($sformatf("vec%0d_busy", k), o_busy, 0);
    end
    v0 = n_valid;
    send_byte(8'h00, 1'b1, BT);
    send_byte(8'hFF, 1'b1, BT);
    drive(1'b1, 2 * BT);
    n = cap.size();
    check("b2b_valid_cnt", n_valid - v0, 2);
    check("b2b_first", (n >= 2) ? cap[n-2] : -1, 8'h00);
    check("b2b_second", (n >= 1) ? cap[n-1] : -1, 8'hFF);
    v0 = n_valid;
    f0 = n_ferr;
    b0 = n_busy;
    drive(1'b0, 8);
    drive(1'b1, 60);
    check("glitch_busy_seen", (n_busy - b0) > 0, 1);
    check("glitch_busy_after", o_busy, 0);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    v0 = n_valid;
    f0 = n_ferr;
    send_byte(8'h3C, 1'b0, BT);
    drive(1'b0, 3 * BT);
    check("ferr_cnt", n_ferr - f0, 1);
    check("ferr_valid", n_valid - v0, 0);
    check("ferr_data_kept", o_data, 8'hFF);
    check("ferr_busy_low_line", o_busy, 1);
    drive(1'b1, 10);
    check("ferr_busy_released", o_busy, 0);
    v0 = n_valid;
    drive(1'b0, BT);
    for (int i = 0; i < 4; i++) drive(i[0] ^ i[1] ? 1'b1 : 1'b0, BT);
    drive(1'b1, HT);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_data", o_data, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2 * BT);
    check("rst_after_busy", o_busy, 0);
    check("rst_after_valid", n_valid - v0, 0);
    f0 = n_ferr;
    send_byte(8'h5A, 1'b1, BT);
    drive(1'b1, 2 * BT);
    check("rst_5a_valid", n_valid - v0, 1);
    check("rst_5a_data", o_data, 8'h5A);
    check("rst_5a_ferr", n_ferr - f0, 0);
    check("valid_ferr_overlap", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
